// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking and event
// pulses, gated by a pixel clock enable and a run/stop state machine that finishes whole frames.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk60MHz_i,
    input  logic             rst_n,
    input  logic             pix_ce_i,
    input  logic             run_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] irq_line_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             hblnk_o,
    output logic             vblnk_o,
    output logic             de_o,
    output logic             frame_start_o,
    output logic             line_start_o,
    output logic             line_match_o,
    output logic             running_o
);
    localparam int unsigned     H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned     V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_param_check
        $error("vga_timing_gen: timing parameters must be >= 1 and totals must fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLANK = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLANK = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StStop = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] h_adv, v_adv;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d, vblnk_q, vblnk_d, de_q, de_d;
    logic             fs_q, fs_d, ls_q, ls_d, lm_q, lm_d, running_q, running_d;
    logic             pulse_en, at_last;

    always_comb begin
        h_adv = hcnt_q + CNT_W'(1);
        v_adv = vcnt_q;
        if (hcnt_q == H_LAST) begin
            h_adv = '0;
            v_adv = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    assign at_last = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

    // pulse_en marks a cycle in which the displayed position is freshly entered.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        pulse_en = 1'b0;
        if (restart_i) begin
            hcnt_d   = '0;
            vcnt_d   = '0;
            pulse_en = (state_q != StIdle);
        end else if (pix_ce_i) begin
            case (state_q)
                StIdle: begin
                    if (run_i) begin
                        state_d  = StRun;
                        pulse_en = 1'b1;
                    end
                end
                StRun: begin
                    if (!run_i) state_d = StStop;
                    hcnt_d   = h_adv;
                    vcnt_d   = v_adv;
                    pulse_en = 1'b1;
                end
                StStop: begin
                    if (run_i) state_d = StRun;
                    else if (at_last) state_d = StIdle;
                    hcnt_d   = h_adv;
                    vcnt_d   = v_adv;
                    pulse_en = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next position so they line up with the registered counters.
    always_comb begin
        running_d = (state_d != StIdle);
        hblnk_d   = 1'b1;
        vblnk_d   = 1'b1;
        hsync_d   = ~HSYNC_POL;
        vsync_d   = ~VSYNC_POL;
        if (running_d) begin
            hblnk_d = (hcnt_d >= H_BLANK);
            vblnk_d = (vcnt_d >= V_BLANK);
            hsync_d = (hcnt_d >= HS_BEG && hcnt_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = (vcnt_d >= VS_BEG && vcnt_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        end
        de_d = ~hblnk_d & ~vblnk_d;
        ls_d = pulse_en && running_d && (hcnt_d == '0);
        fs_d = ls_d && (vcnt_d == '0);
        lm_d = ls_d && (vcnt_d == irq_line_i);
    end

    always_ff @(posedge clk60MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            hblnk_q   <= 1'b1;
            vblnk_q   <= 1'b1;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
            lm_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            hblnk_q   <= hblnk_d;
            vblnk_q   <= vblnk_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
            lm_q      <= lm_d;
            running_q <= running_d;
        end
    end

    assign hcount_o      = hcnt_q;
    assign vcount_o      = vcnt_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign hblnk_o       = hblnk_q;
    assign vblnk_o       = vblnk_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign line_start_o  = ls_q;
    assign line_match_o  = lm_q;
    assign running_o     = running_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 88, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 Parameter V_BP, default 23, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, default 1, asserted level of hsync.
REQ-010 Parameter VSYNC_POL, default 1, asserted level of vsync.
REQ-011 Parameter CNT_W, default 11, width of counters and irq_line.
REQ-012 clk60MHz  in  1  system clock; all logic on rising edge.
REQ-013 rst_n  in  1  asynchronous, active-low reset.
REQ-014 pix_ce  in  1  pixel clock enable; timing advances only when high.
REQ-015 run  in  1  request to generate frames.
REQ-016 restart  in  1  synchronous restart to position (0,0).
REQ-017 irq_line  in  CNT_W  line number for line_match.
REQ-018 hcount, vcount  out  CNT_W each  current pixel position.
REQ-019 hsync, vsync  out  1 each  sync outputs at polarity HSYNC_POL/VSYNC_POL.
REQ-020 hblnk, vblnk, de  out  1 each  blanking flags; de = !hblnk && !vblnk.
REQ-021 frame_start, line_start, line_match  out  1 each  single-clock pulses.
REQ-022 running  out  1  high in RUN and STOPPING states.

Function
REQ-023 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL defined likewise; both SHALL fit in CNT_W bits, with each porch, sync, and active parameter >= 1 (elaboration error otherwise).
REQ-024 All outputs SHALL be registered and SHALL describe the pixel at the current hcount/vcount; zero combinational paths from inputs to outputs.
REQ-025 On each pix_ce in RUN/STOPPING: hcount increments, wrapping H_TOTAL-1 -> 0; on wrap, vcount increments, wrapping V_TOTAL-1 -> 0.
REQ-026 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE.
REQ-027 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync SHALL be asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for the whole line including hcount=0.
REQ-028 With pix_ce low, all counters and levels SHALL hold, and all pulses SHALL be 0.
REQ-029 line_start SHALL pulse for one clk when outputs first show hcount=0; frame_start likewise when outputs first show (0,0); line_match likewise when outputs first show (0,irq_line).
REQ-030 irq_line >= V_TOTAL SHALL never produce line_match.
REQ-031 FSM states are IDLE, RUN, and STOPPING; transitions are evaluated only on pix_ce.
REQ-032 In IDLE: counters hold 0, hblnk=vblnk=1, de=0, syncs inactive, and pulses 0; run=1 -> RUN, presenting (0,0) with frame_start on the next ce.
REQ-033 In RUN: run=0 -> STOPPING; counting continues.
REQ-034 In STOPPING: run=1 -> RUN without disturbing counters; at (H_TOTAL-1,V_TOTAL-1) the next ce goes to IDLE, never truncating a frame.
REQ-035 When restart=1 (regardless of pix_ce), the next clk SHALL show (0,0) with levels decoded for (0,0), with frame_start and line_start pulsed if in RUN or STOPPING; state is unchanged, and restart overrides run in the same cycle.

Reset
REQ-036 While rst_n=0: state=IDLE, hcount=vcount=0, hblnk=vblnk=1, de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, all pulses=0, and running=0.
REQ-037 Reset assertion SHALL take effect immediately mid-frame; after release, the block SHALL stay in IDLE until run=1 is sampled with pix_ce.

Verification
REQ-038 Defaults, pix_ce=1, run=1: hsync high for hcount 840..967, hblnk for 800..1055, vsync for vcount 601..604, frame_start every 663168 clks.
REQ-039 pix_ce toggling 1/0: frame period of 1326336 clks, outputs frozen in ce-low cycles, pulses exactly one clk wide.
REQ-040 HSYNC_POL=0, VSYNC_POL=0: reset shows hsync=vsync=1; hsync low only at hcount 840..967.
REQ-041 run dropped at (100,300) -> running stays 1 until (1055,627), then IDLE at (0,0) with de=0; run reasserted at (5,10) -> no stop.
REQ-042 irq_line=599 -> one line_match per frame at (0,599); irq_line=700 -> none; restart at (500,200) -> next clk (0,0) with frame_start=1.
REQ-043 rst_n pulsed low at (400,400) -> outputs immediately at reset values; no frame_start until run is sampled high.
